// File: rtl/rvc_asap_5pl_lsu_if.sv
// rvc_asap_5pl_lsu_if: memory-side bus between the LSU and a synchronous data memory
//   address  32  access address (LSU -> memory)
//   data     32  lane-aligned write data (LSU -> memory)
//   byteena   4  byte lane enables (LSU -> memory)
//   wren      1  write strobe (LSU -> memory)
//   rden      1  read strobe (LSU -> memory)
//   q        32  read data, valid one cycle after rden (memory -> LSU)
interface rvc_asap_5pl_lsu_if;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byteena;
    logic        wren;
    logic        rden;
    logic [31:0] q;
    modport master (output address, data, byteena, wren, rden, input q);
    modport slave  (input address, data, byteena, wren, rden, output q);
endinterface

// File: rtl/rvc_asap_5pl_lsu.sv
// rvc_asap_5pl_lsu: load/store unit, Q103H issue stage and Q104H load formatting
//   Clock, Rst             rising-edge clock, asynchronous active-low reset
//   CtrlLoadQ103H/Store    load / store request (both set -> store)
//   CtrlFunct3Q103H        access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   AluOutQ103H            byte address
//   RegRdData2Q103H        store data
//   mem                    memory bus (rvc_asap_5pl_lsu_if master)
//   StallQ103H             hold Q103H one cycle (first half of a split access)
//   LoadDataQ104H          formatted load result, 0 when not valid
//   LoadValidQ104H         LoadDataQ104H is final
//   MisalignQ103H          misaligned load/store present
// Define RVC_ASAP_LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two
// word accesses; otherwise misaligned accesses are suppressed.
module rvc_asap_5pl_lsu (
    input  logic                      Clock,
    input  logic                      Rst,
    input  logic                      CtrlLoadQ103H,
    input  logic                      CtrlStoreQ103H,
    input  logic [2:0]                CtrlFunct3Q103H,
    input  logic [31:0]               AluOutQ103H,
    input  logic [31:0]               RegRdData2Q103H,
    rvc_asap_5pl_lsu_if.master        mem,
    output logic                      StallQ103H,
    output logic [31:0]               LoadDataQ104H,
    output logic                      LoadValidQ104H,
    output logic                      MisalignQ103H
);
`ifdef RVC_ASAP_LSU_MISALIGN_SPLIT_EN
    localparam logic split_en = 1'b1;
`else
    localparam logic split_en = 1'b0;
`endif
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t      state;
    logic [1:0]  off, off_q;
    logic [2:0]  f3_q;
    logic        access, is_load, misalign, in_split, first, blocked;
    logic        valid_q, split_q;
    logic [3:0]  base_mask;
    logic [7:0]  mask8;
    logic [63:0] wide_wr, wide_rd;
    logic [31:0] base_addr, hold, raw, ext;
    assign off       = AluOutQ103H[1:0];
    assign access    = CtrlLoadQ103H | CtrlStoreQ103H;
    assign is_load   = CtrlLoadQ103H & ~CtrlStoreQ103H;
    assign misalign  = access & ((CtrlFunct3Q103H[1:0] == 2'b01 && off == 2'd3) ||
                                 (CtrlFunct3Q103H[1] && off != 2'd0));
    assign in_split  = state == SPLIT;
    assign first     = split_en && misalign && !in_split;
    assign blocked   = !split_en && misalign;
    assign base_mask = CtrlFunct3Q103H[1] ? 4'hf : CtrlFunct3Q103H[0] ? 4'h3 : 4'h1;
    // Lanes [3:0] belong to the first word, [7:4] spill into the next word.
    assign mask8     = {4'b0, base_mask} << off;
    assign wide_wr   = {32'b0, RegRdData2Q103H} << {off, 3'b000};
    assign base_addr = {AluOutQ103H[31:2], 2'b00};
    assign mem.address = in_split ? base_addr + 32'd4 : first ? base_addr : AluOutQ103H;
    assign mem.byteena = (!access || blocked) ? 4'b0 : in_split ? mask8[7:4] : mask8[3:0];
    assign mem.data    = in_split ? wide_wr[63:32] : wide_wr[31:0];
    assign mem.wren    = Rst && CtrlStoreQ103H && !blocked;
    assign mem.rden    = Rst && is_load && !blocked;
    assign StallQ103H    = first;
    assign MisalignQ103H = misalign;
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            hold    <= '0;
            valid_q <= 1'b0;
            split_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state   <= first ? SPLIT : IDLE;
            valid_q <= in_split ? is_load : is_load & ~misalign;
            split_q <= in_split;
            f3_q    <= CtrlFunct3Q103H;
            off_q   <= off;
            // q of the first half arrives during the SPLIT cycle
            if (in_split) hold <= mem.q;
        end
    end
    assign wide_rd = split_q ? {mem.q, hold} : {32'b0, mem.q};
    assign raw     = 32'(wide_rd >> {off_q, 3'b000});
    assign ext     = f3_q[1] ? raw :
                     f3_q[0] ? {{16{~f3_q[2] & raw[15]}}, raw[15:0]} :
                               {{24{~f3_q[2] & raw[7]}}, raw[7:0]};
    assign LoadValidQ104H = valid_q;
    assign LoadDataQ104H  = valid_q ? ext : 32'b0;
endmodule

// File: tb/tb_rvc_asap_5pl_lsu.sv
// tb_rvc_asap_5pl_lsu: randomized and directed checks of rvc_asap_5pl_lsu against a byte-level memory model
module tb_rvc_asap_5pl_lsu;
    localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;
    logic        Clock = 1'b0, Rst = 1'b0;
    logic        ld = 1'b0, st = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] alu = '0, wd = '0;
    logic        stall, lvalid, mis;
    logic [31:0] ldata;
    int          n_tests = 0, n_fail = 0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data = '0;
    logic [7:0]  ref_m [64];
    logic [7:0]  mem_b [64];
    logic [31:0] rd_q;

    rvc_asap_5pl_lsu_if bus();

    rvc_asap_5pl_lsu dut (
        .Clock(Clock), .Rst(Rst),
        .CtrlLoadQ103H(ld), .CtrlStoreQ103H(st), .CtrlFunct3Q103H(f3),
        .AluOutQ103H(alu), .RegRdData2Q103H(wd),
        .mem(bus),
        .StallQ103H(stall), .LoadDataQ104H(ldata), .LoadValidQ104H(lvalid), .MisalignQ103H(mis)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] init_byte(int i);
        return 8'(i * 37 + 11);
    endfunction

    // memory slave: 64-byte window aliased by address[5:0], one-cycle read latency
    assign bus.q = rd_q;
    always @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= init_byte(i);
            rd_q <= '0;
        end else begin
            if (bus.wren)
                for (int i = 0; i < 4; i++)
                    if (bus.byteena[i]) mem_b[{bus.address[5:2], 2'(i)}] <= bus.data[8*i +: 8];
            if (bus.rden)
                rd_q <= {mem_b[{bus.address[5:2], 2'd3}], mem_b[{bus.address[5:2], 2'd2}],
                         mem_b[{bus.address[5:2], 2'd1}], mem_b[{bus.address[5:2], 2'd0}]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reinit_ref();
        for (int i = 0; i < 64; i++) ref_m[i] = init_byte(i);
    endtask

    // one cycle: drive Q103H inputs after the falling edge, then check Q104H of the previous issue
    task automatic drive(input logic l, input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        @(negedge Clock);
        ld = l; st = s; f3 = f; alu = a; wd = w;
        #1;
        check("lvalid", 32'(lvalid), 32'(pend_valid));
        check("ldata", ldata, pend_valid ? pend_data : 32'b0);
        pend_valid = 1'b0;
    endtask

    task automatic do_op(input logic l, input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        int          n, off;
        logic        acc, isld, misx;
        logic [7:0]  e [8];
        logic [7:0]  be;
        logic [31:0] v, base;
        n    = f[1] ? 4 : f[0] ? 2 : 1;
        off  = int'(a[1:0]);
        acc  = l | s;
        isld = l & ~s;
        misx = acc && (off + n > 4);
        base = a & 32'hFFFF_FFFC;
        be   = '0;
        v    = '0;
        for (int i = 0; i < 8; i++) e[i] = 8'h00;
        for (int i = 0; i < 4; i++) e[off + i] = w[8*i +: 8];
        for (int i = 0; i < n; i++) be[off + i] = 1'b1;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_m[6'(a + 32'(i))];
        if (!f[2] && n == 1 && v[7])  v[31:8]  = '1;
        if (!f[2] && n == 2 && v[15]) v[31:16] = '1;
        drive(l, s, f, a, w);
        check("misalign", 32'(mis), 32'(misx));
        if (!acc) begin
            check("idle_wren", 32'(bus.wren), 0);
            check("idle_rden", 32'(bus.rden), 0);
            check("idle_be", 32'(bus.byteena), 0);
            check("idle_stall", 32'(stall), 0);
        end else if (!misx) begin
            check("addr", bus.address, a);
            check("be", 32'(bus.byteena), 32'(be[3:0]));
            check("data", bus.data, {e[3], e[2], e[1], e[0]});
            check("wren", 32'(bus.wren), 32'(s));
            check("rden", 32'(bus.rden), 32'(isld));
            check("stall", 32'(stall), 0);
            if (s) for (int i = 0; i < n; i++) ref_m[6'(a + 32'(i))] = w[8*i +: 8];
            pend_valid = isld;
            pend_data  = v;
        end else begin
`ifdef RVC_ASAP_LSU_MISALIGN_SPLIT_EN
            check("s1_addr", bus.address, base);
            check("s1_be", 32'(bus.byteena), 32'(be[3:0]));
            check("s1_data", bus.data, {e[3], e[2], e[1], e[0]});
            check("s1_wren", 32'(bus.wren), 32'(s));
            check("s1_rden", 32'(bus.rden), 32'(isld));
            check("s1_stall", 32'(stall), 1);
            drive(l, s, f, a, w);
            check("s2_addr", bus.address, base + 32'd4);
            check("s2_be", 32'(bus.byteena), 32'(be[7:4]));
            check("s2_data", bus.data, {e[7], e[6], e[5], e[4]});
            check("s2_wren", 32'(bus.wren), 32'(s));
            check("s2_rden", 32'(bus.rden), 32'(isld));
            check("s2_stall", 32'(stall), 0);
            check("s2_misalign", 32'(mis), 1);
            if (s) for (int i = 0; i < n; i++) ref_m[6'(a + 32'(i))] = w[8*i +: 8];
            pend_valid = isld;
            pend_data  = v;
`else
            check("blk_wren", 32'(bus.wren), 0);
            check("blk_rden", 32'(bus.rden), 0);
            check("blk_be", 32'(bus.byteena), 0);
            check("blk_stall", 32'(stall), 0);
`endif
        end
    endtask

    initial begin
        logic [2:0] fl [5];
        fl = '{FB, FH, FW, FBU, FHU};
        reinit_ref();
        // reset: outputs follow inputs, strobes gated, Q104H cleared
        @(negedge Clock);
        ld = 1'b1; f3 = FW; alu = 32'h0000_1004;
        #1;
        check("rst_rden", 32'(bus.rden), 0);
        check("rst_addr", bus.address, 32'h0000_1004);
        check("rst_lvalid", 32'(lvalid), 0);
        check("rst_ldata", ldata, 0);
        @(negedge Clock);
        ld = 1'b0; st = 1'b1;
        #1;
        check("rst_wren", 32'(bus.wren), 0);
        @(negedge Clock);
        ld = 1'b0; st = 1'b0;
        Rst = 1'b1;
        // directed examples
        do_op(0, 1, FW,  32'h0000_1000, 32'hAABB_CCDD);
        do_op(0, 1, FW,  32'h0000_1000, 32'h80FF_FFFF);
        do_op(1, 0, FB,  32'h0000_1003, 32'h0);
        do_op(1, 0, FBU, 32'h0000_1003, 32'h0);
        do_op(0, 1, FH,  32'h0000_1002, 32'h0000_1234);
        do_op(0, 1, FW,  32'h0000_1000, 32'h5678_0000);
        do_op(1, 0, FHU, 32'h0000_1002, 32'h0);
        do_op(0, 1, FW,  32'h0000_1000, 32'h3322_11AA);
        do_op(0, 1, FW,  32'h0000_1004, 32'h5566_7744);
        do_op(1, 0, FW,  32'h0000_1001, 32'h0);
        do_op(0, 1, FW,  32'hFFFF_FFFE, 32'hDDCC_BBAA);
        do_op(1, 0, FW,  32'hFFFF_FFFE, 32'h0);
        do_op(1, 1, FW,  32'h0000_1008, 32'h0102_0304);
        do_op(1, 0, FH,  32'h0000_1003, 32'h0);
        do_op(0, 1, FW,  32'h0000_1001, 32'h1357_9BDF);
        do_op(0, 0, FW,  32'h0000_1001, 32'h0);
        // reset with a load result pending clears Q104H immediately
        do_op(1, 0, FW, 32'h0000_1000, 32'h0);
        @(negedge Clock);
        ld = 1'b0; Rst = 1'b0; reinit_ref(); pend_valid = 1'b0;
        #1;
        check("arst_lvalid", 32'(lvalid), 0);
        check("arst_ldata", ldata, 0);
        @(negedge Clock);
        Rst = 1'b1;
`ifdef RVC_ASAP_LSU_MISALIGN_SPLIT_EN
        // reset during the second half abandons it; release restarts from the first half
        drive(1, 0, FW, 32'h0000_1001, 32'h0);
        check("rs_stall1", 32'(stall), 1);
        @(negedge Clock);
        Rst = 1'b0; reinit_ref();
        #1;
        check("rs_rden", 32'(bus.rden), 0);
        check("rs_wren", 32'(bus.wren), 0);
        check("rs_lvalid", 32'(lvalid), 0);
        @(negedge Clock);
        Rst = 1'b1;
        #1;
        check("rs_restart_addr", bus.address, 32'h0000_1000);
        check("rs_restart_stall", 32'(stall), 1);
        drive(0, 0, FW, 32'h0000_1001, 32'h0);
        check("rs_idle_rden", 32'(bus.rden), 0);
        check("rs_idle_be", 32'(bus.byteena), 0);
        drive(0, 0, FW, 32'h0, 32'h0);
        check("rs_after_stall", 32'(stall), 0);
`endif
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                            : 32'h0000_1000 + 32'($urandom_range(0, 63));
            do_op(r < 4 || r == 8, r >= 4 && r <= 8, fl[$urandom_range(0, 4)], a, $urandom);
        end
        drive(0, 0, FW, 32'h0, 32'h0);
        drive(0, 0, FW, 32'h0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
